// File: rtl/mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter
//   Round-robin arbiter sharing one WIDTH-bit 4:1 mux path among four
//   valid/ready requesters. The winning word is registered onto a single
//   valid/ready output port. o_sel is the mux select of the last grant.
//
// Ports
//   i_clk        clock, all state updates on posedge
//   i_reset      synchronous active-high reset
//   i_req_valid  per-requester valid
//   i_req_data0..3  per-requester data
//   o_req_ready  one-hot or zero, combinational, ready to the winner
//   o_out_valid  o_out_data holds an unconsumed word
//   o_out_data   registered data of the last granted requester
//   i_out_ready  consumer accepts o_out_data when o_out_valid & i_out_ready
//   o_sel        index of the last granted requester
//   o_grant      one-hot of o_sel while o_out_valid, else zero
// ---------------------------------------------------------------------------
module mux4_rr_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [3:0]       i_req_valid,
    input  logic [WIDTH-1:0] i_req_data0,
    input  logic [WIDTH-1:0] i_req_data1,
    input  logic [WIDTH-1:0] i_req_data2,
    input  logic [WIDTH-1:0] i_req_data3,
    output logic [3:0]       o_req_ready,
    output logic             o_out_valid,
    output logic [WIDTH-1:0] o_out_data,
    input  logic             i_out_ready,
    output logic [1:0]       o_sel,
    output logic [3:0]       o_grant
);

    logic             r_out_valid;
    logic [1:0]       r_ptr;
    logic [WIDTH-1:0] r_out_data;
    logic [1:0]       r_sel;

    logic             w_accept;
    logic             w_any;
    logic             w_take;
    logic [1:0]       w_win;
    logic [WIDTH-1:0] w_win_data;

    // Slot is free, or its current word drains this very cycle.
    assign w_accept = ~r_out_valid | i_out_ready;
    assign w_any    = |i_req_valid;
    assign w_take   = w_accept & w_any & ~i_reset;

    // First valid requester scanning from the priority pointer, wrapping mod 4.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        w_win = r_ptr;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = r_ptr + 2'(k);
            if (!found && i_req_valid[idx]) begin
                w_win = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        w_win_data = '0;
        unique case (w_win)
            2'd0: w_win_data = i_req_data0;
            2'd1: w_win_data = i_req_data1;
            2'd2: w_win_data = i_req_data2;
            2'd3: w_win_data = i_req_data3;
            default: w_win_data = '0;
        endcase
    end

    always_comb begin
        o_req_ready = 4'b0000;
        if (w_take) begin
            o_req_ready[w_win] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_out_valid <= 1'b0;
            r_ptr       <= 2'd0;
            r_out_data  <= '0;
            r_sel       <= 2'd0;
        end else if (w_take) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_win_data;
            r_sel       <= w_win;
            r_ptr       <= w_win + 2'd1;
        end else if (r_out_valid && i_out_ready) begin
            // Drained with nothing new to load; data and select hold.
            r_out_valid <= 1'b0;
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_sel       = r_sel;

    always_comb begin
        o_grant = 4'b0000;
        if (r_out_valid) begin
            o_grant[r_sel] = 1'b1;
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux4_rr_arbiter
//   Directed self-checking bench for mux4_rr_arbiter: reset, single request,
//   round-robin order, backpressure, pointer wrap/skip, reset mid-stream.
// ---------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req_valid;
    logic [7:0] req_data0;
    logic [7:0] req_data1;
    logic [7:0] req_data2;
    logic [7:0] req_data3;
    logic [3:0] req_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [1:0] sel;
    logic [3:0] grant;

    int n_total;
    int n_bad;

    mux4_rr_arbiter #(
        .WIDTH(8)
    ) u_dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_req_valid (req_valid),
        .i_req_data0 (req_data0),
        .i_req_data1 (req_data1),
        .i_req_data2 (req_data2),
        .i_req_data3 (req_data3),
        .o_req_ready (req_ready),
        .o_out_valid (out_valid),
        .o_out_data  (out_data),
        .i_out_ready (out_ready),
        .o_sel       (sel),
        .o_grant     (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance past the next active edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [7:0] exp_data, input logic [1:0] exp_sel);
        check_eq({tag, ".valid"}, 16'(out_valid), 16'd1);
        check_eq({tag, ".data"},  16'(out_data),  16'(exp_data));
        check_eq({tag, ".sel"},   16'(sel),       16'(exp_sel));
        check_eq({tag, ".grant"}, 16'(grant),     16'(4'b0001 << exp_sel));
    endtask

    initial begin
        logic [7:0] rr_data [4];
        n_total   = 0;
        n_bad     = 0;
        rr_data[0] = 8'h01;
        rr_data[1] = 8'h02;
        rr_data[2] = 8'h04;
        rr_data[3] = 8'h08;

        req_data0 = 8'h01;
        req_data1 = 8'h02;
        req_data2 = 8'h04;
        req_data3 = 8'h08;

        // 1 Reset with all requesters valid.
        reset     = 1'b1;
        req_valid = 4'hF;
        out_ready = 1'b1;
        step();
        step();
        check_eq("rst.req_ready", 16'(req_ready), 16'h0);
        check_eq("rst.out_valid", 16'(out_valid), 16'h0);
        check_eq("rst.sel",       16'(sel),       16'h0);
        check_eq("rst.grant",     16'(grant),     16'h0);

        // 2 Single requester.
        reset     = 1'b0;
        req_valid = 4'b0100;
        #1;
        check_eq("single.req_ready", 16'(req_ready), 16'b0100);
        step();
        check_out("single", 8'h04, 2'd2);
        // Drain with nothing pending: valid drops, data/sel hold.
        req_valid = 4'b0000;
        #1;
        check_eq("idle.req_ready", 16'(req_ready), 16'h0);
        step();
        check_eq("drain.out_valid", 16'(out_valid), 16'h0);
        check_eq("drain.grant",     16'(grant),     16'h0);
        check_eq("drain.sel",       16'(sel),       16'd2);
        check_eq("drain.data",      16'(out_data),  16'h04);

        // 3 Round-robin from ptr=0.
        reset = 1'b1;
        step();
        reset     = 1'b0;
        req_valid = 4'hF;
        for (int i = 0; i < 8; i++) begin
            step();
            check_out($sformatf("rr%0d", i), rr_data[i % 4], 2'(i % 4));
        end

        // 4 Backpressure while holding 8'h02 from requester 1.
        step();
        check_out("bp.pre0", 8'h01, 2'd0);
        step();
        check_out("bp.pre1", 8'h02, 2'd1);
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("bp%0d.req_ready", i), 16'(req_ready), 16'h0);
            step();
            check_out($sformatf("bp%0d", i), 8'h02, 2'd1);
        end
        out_ready = 1'b1;
        #1;
        check_eq("bp.release.req_ready", 16'(req_ready), 16'b0100);
        step();
        check_out("bp.next", 8'h04, 2'd2);

        // 5 Wrap/skip: ptr is 3 now.
        req_valid = 4'b0010;
        #1;
        check_eq("wrap.req_ready", 16'(req_ready), 16'b0010);
        step();
        check_out("wrap", 8'h02, 2'd1);
        req_valid = 4'b1001;
        #1;
        check_eq("skip.req_ready", 16'(req_ready), 16'b1000);
        step();
        check_out("skip", 8'h08, 2'd3);

        // 6 Reset mid-stream with a pending word under backpressure.
        out_ready = 1'b0;
        req_valid = 4'hF;
        reset     = 1'b1;
        #1;
        check_eq("midrst.req_ready", 16'(req_ready), 16'h0);
        step();
        check_eq("midrst.out_valid", 16'(out_valid), 16'h0);
        check_eq("midrst.grant",     16'(grant),     16'h0);
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        check_eq("post.req_ready", 16'(req_ready), 16'b0001);
        step();
        check_out("post", 8'h01, 2'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Safety net against a stalled simulation.
    initial begin
        #100000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule
